// File: rtl/systolic_feeder_if.sv
// Operand slice stream into the systolic feeder: valid/ready handshake carrying one
// A-column / B-row slice per beat.
interface systolic_feeder_if;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic signed [7:0] in_a1;
  logic signed [7:0] in_a2;
  logic signed [7:0] in_b1;
  logic signed [7:0] in_b2;

  modport master (
    output in_valid, in_last, in_a1, in_a2, in_b1, in_b2,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, in_a1, in_a2, in_b1, in_b2,
    output in_ready
  );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers a K-deep operand stream and replays it diagonally skewed, with array controls,
// into the 2x2 int8 systolic block. Define SYSTOLIC_FEEDER_REPLAY_EN to enable operand replay.
module systolic_feeder #(
  parameter int unsigned KMAX = 16,
  localparam int unsigned KW = $clog2(KMAX + 1),
  localparam int unsigned RW = $clog2(KMAX + 7),
  localparam int unsigned IW = (KMAX > 1) ? $clog2(KMAX) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  systolic_feeder_if.slave     in_if,
  input  logic                 replay,
  output logic                 busy,
  output logic                 done,
  output logic [KW-1:0]        k_len,
  output logic signed [7:0]    a1X,
  output logic signed [7:0]    a2X,
  output logic signed [7:0]    bX1,
  output logic signed [7:0]    bX2,
  output logic                 start,
  output logic                 enable,
  output logic                 push11,
  output logic                 pushedge,
  output logic                 push22
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     r_q, r_d;
  logic [KW-1:0]     count_q, count_d, k_len_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_d, done_d, start_d, enable_d;
  logic              push11_d, pushedge_d, push22_d;
  logic signed [7:0] a1x_d, a2x_d, bx1_d, bx2_d;

  logic signed [7:0] a0_buf [KMAX];
  logic signed [7:0] a1_buf [KMAX];
  logic signed [7:0] b0_buf [KMAX];
  logic signed [7:0] b1_buf [KMAX];

  logic              accept, last_beat, replay_go, go, run_d;
  int unsigned       r_i, k_i;

`ifdef SYSTOLIC_FEEDER_REPLAY_EN
  // A simultaneous beat takes priority over replay.
  assign replay_go = (state_q == StIdle) && in_ready_q && replay && !in_if.in_valid &&
                     (count_q == '0) && (k_len != '0);
`else
  logic unused_replay;
  assign unused_replay = replay;
  assign replay_go     = 1'b0;
`endif

  assign in_if.in_ready = in_ready_q;

  // Everything below describes the *next* cycle so every output leaves a flop.
  always_comb begin
    accept    = (state_q == StIdle) && in_ready_q && in_if.in_valid;
    last_beat = accept && (in_if.in_last || (32'(count_q) == KMAX - 1));
    go        = last_beat || replay_go;
    k_i       = last_beat ? 32'(count_q) + 1 : 32'(k_len);

    run_d = 1'b0;
    r_i   = 0;
    if (go) begin
      run_d = 1'b1;
    end else if ((state_q == StRun) && (32'(r_q) != k_i + 6)) begin
      run_d = 1'b1;
      r_i   = 32'(r_q) + 1;
    end
    state_d = run_d ? StRun : StIdle;

    count_d = count_q;
    if (accept) begin
      count_d = count_q + 1'b1;
    end else if ((state_q == StRun) && !run_d) begin
      count_d = '0;
    end

    k_len_d    = KW'(k_i);
    r_d        = RW'(r_i);
    in_ready_d = !run_d;

    busy_d     = 1'b0;
    done_d     = 1'b0;
    start_d    = 1'b0;
    enable_d   = 1'b0;
    push11_d   = 1'b0;
    pushedge_d = 1'b0;
    push22_d   = 1'b0;
    a1x_d      = '0;
    a2x_d      = '0;
    bx1_d      = '0;
    bx2_d      = '0;
    if (run_d) begin
      busy_d     = 1'b1;
      start_d    = (r_i == 0);
      enable_d   = (r_i >= 1) && (r_i <= k_i + 2);
      push11_d   = (r_i == k_i + 3);
      pushedge_d = (r_i == k_i + 4);
      push22_d   = (r_i == k_i + 5);
      done_d     = (r_i == k_i + 6);
      // Row 2 / column 2 lag row 1 / column 1 by one cycle to form the diagonal wavefront.
      if ((r_i >= 1) && (r_i <= k_i)) begin
        a1x_d = a0_buf[IW'(r_i - 1)];
        bx1_d = b0_buf[IW'(r_i - 1)];
      end
      if ((r_i >= 2) && (r_i <= k_i + 1)) begin
        a2x_d = a1_buf[IW'(r_i - 2)];
        bx2_d = b1_buf[IW'(r_i - 2)];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      r_q        <= '0;
      count_q    <= '0;
      k_len      <= '0;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start      <= 1'b0;
      enable     <= 1'b0;
      push11     <= 1'b0;
      pushedge   <= 1'b0;
      push22     <= 1'b0;
      a1X        <= '0;
      a2X        <= '0;
      bX1        <= '0;
      bX2        <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      count_q    <= count_d;
      k_len      <= k_len_d;
      in_ready_q <= in_ready_d;
      busy       <= busy_d;
      done       <= done_d;
      start      <= start_d;
      enable     <= enable_d;
      push11     <= push11_d;
      pushedge   <= pushedge_d;
      push22     <= push22_d;
      a1X        <= a1x_d;
      a2X        <= a2x_d;
      bX1        <= bx1_d;
      bX2        <= bx2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a0_buf[count_q[IW-1:0]] <= in_if.in_a1;
      a1_buf[count_q[IW-1:0]] <= in_if.in_a2;
      b0_buf[count_q[IW-1:0]] <= in_if.in_b1;
      b1_buf[count_q[IW-1:0]] <= in_if.in_b2;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural 2x2 systolic array on its outputs.
module tb_systolic_feeder;

  logic clk = 1'b0;
  logic reset;
  logic replay;
  always #5 clk = ~clk;

  systolic_feeder_if sf_if ();

  logic              busy, done, start, enable, push11, pushedge, push22;
  logic [4:0]        k_len;
  logic signed [7:0] a1X, a2X, bX1, bX2;

  systolic_feeder #(.KMAX(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_if    (sf_if),
    .replay   (replay),
    .busy     (busy),
    .done     (done),
    .k_len    (k_len),
    .a1X      (a1X),
    .a2X      (a2X),
    .bX1      (bX1),
    .bX2      (bX2),
    .start    (start),
    .enable   (enable),
    .push11   (push11),
    .pushedge (pushedge),
    .push22   (push22)
  );

  int checks = 0;
  int failures = 0;
  int op_a0[16], op_a1[16], op_b0[16], op_b1[16];

  // Reference 2x2 output-stationary array: operands flow right/down one PE per cycle.
  int c11, c12, c21, c22, a1d, a2d, b1d, b2d;
  always @(posedge clk or posedge reset) begin
    if (reset || start) begin
      c11 <= 0; c12 <= 0; c21 <= 0; c22 <= 0;
      a1d <= 0; a2d <= 0; b1d <= 0; b2d <= 0;
    end else begin
      if (enable) begin
        c11 <= c11 + int'(a1X) * int'(bX1);
        c12 <= c12 + a1d * int'(bX2);
        c21 <= c21 + int'(a2X) * b1d;
        c22 <= c22 + a2d * b2d;
      end
      a1d <= int'(a1X); a2d <= int'(a2X); b1d <= int'(bX1); b2d <= int'(bX2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input logic exp_ready);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " start"}, start, 0);
    check({tag, " enable"}, enable, 0);
    check({tag, " push11"}, push11, 0);
    check({tag, " pushedge"}, pushedge, 0);
    check({tag, " push22"}, push22, 0);
    check({tag, " a1X"}, a1X, 0);
    check({tag, " a2X"}, a2X, 0);
    check({tag, " bX1"}, bX1, 0);
    check({tag, " bX2"}, bX2, 0);
    check({tag, " in_ready"}, sf_if.in_ready, exp_ready);
  endtask

  task automatic load(input int k, input bit use_last);
    for (int i = 0; i < k; i++) begin
      check($sformatf("load beat%0d in_ready", i), sf_if.in_ready, 1);
      sf_if.in_valid = 1'b1;
      sf_if.in_last  = use_last && (i == k - 1);
      sf_if.in_a1    = 8'(op_a0[i]);
      sf_if.in_a2    = 8'(op_a1[i]);
      sf_if.in_b1    = 8'(op_b0[i]);
      sf_if.in_b2    = 8'(op_b1[i]);
      tick();
    end
    sf_if.in_valid = 1'b0;
    sf_if.in_last  = 1'b0;
  endtask

  // Entered on the r=0 cycle; leaves on the cycle after done.
  task automatic check_run(input string tag, input int k);
    int ea1, ea2, eb1, eb2;
    for (int r = 0; r <= k + 6; r++) begin
      ea1 = (r >= 1 && r <= k) ? op_a0[r-1] : 0;
      eb1 = (r >= 1 && r <= k) ? op_b0[r-1] : 0;
      ea2 = (r >= 2 && r <= k + 1) ? op_a1[r-2] : 0;
      eb2 = (r >= 2 && r <= k + 1) ? op_b1[r-2] : 0;
      check($sformatf("%s r%0d start", tag, r), start, r == 0);
      check($sformatf("%s r%0d enable", tag, r), enable, (r >= 1) && (r <= k + 2));
      check($sformatf("%s r%0d a1X", tag, r), a1X, ea1);
      check($sformatf("%s r%0d a2X", tag, r), a2X, ea2);
      check($sformatf("%s r%0d bX1", tag, r), bX1, eb1);
      check($sformatf("%s r%0d bX2", tag, r), bX2, eb2);
      check($sformatf("%s r%0d push11", tag, r), push11, r == k + 3);
      check($sformatf("%s r%0d pushedge", tag, r), pushedge, r == k + 4);
      check($sformatf("%s r%0d push22", tag, r), push22, r == k + 5);
      check($sformatf("%s r%0d done", tag, r), done, r == k + 6);
      check($sformatf("%s r%0d busy", tag, r), busy, 1);
      check($sformatf("%s r%0d in_ready", tag, r), sf_if.in_ready, 0);
      check($sformatf("%s r%0d k_len", tag, r), k_len, k);
      tick();
    end
    check({tag, " post busy"}, busy, 0);
    check({tag, " post done"}, done, 0);
    check({tag, " post in_ready"}, sf_if.in_ready, 1);
  endtask

  task automatic check_c(input string tag, input int e11, input int e12, input int e21,
                         input int e22);
    check({tag, " c11"}, c11, e11);
    check({tag, " c12"}, c12, e12);
    check({tag, " c21"}, c21, e21);
    check({tag, " c22"}, c22, e22);
  endtask

  task automatic set_k2();
    op_a0[0] = 1; op_a0[1] = 2;
    op_a1[0] = 3; op_a1[1] = 4;
    op_b0[0] = 5; op_b0[1] = 7;
    op_b1[0] = 6; op_b1[1] = 8;
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    replay         = 1'b0;
    sf_if.in_valid = 1'b0;
    sf_if.in_last  = 1'b0;
    sf_if.in_a1    = '0;
    sf_if.in_a2    = '0;
    sf_if.in_b1    = '0;
    sf_if.in_b2    = '0;
    #1 reset = 1'b1;
    #1;
    check_quiet("reset", 0);
    check("reset k_len", k_len, 0);
    tick();
    tick();
    check_quiet("reset held", 0);
    reset = 1'b0;
    check_quiet("reset released", 0);
    tick();
    check_quiet("idle", 1);

    // K=2, A=[1,2;3,4], B=[5,6;7,8]
    set_k2();
    load(2, 1'b1);
    check_run("k2", 2);
    check_c("k2", 19, 22, 43, 50);

    // K=1 extremes; in_valid stays high through the run with a different beat pending
    op_a0[0] = -128; op_a1[0] = 127; op_b0[0] = -128; op_b1[0] = -1;
    load(1, 1'b1);
    sf_if.in_valid = 1'b1;
    sf_if.in_last  = 1'b1;
    sf_if.in_a1    = 8'sd10;
    sf_if.in_a2    = 8'sd20;
    sf_if.in_b1    = 8'sd30;
    sf_if.in_b2    = 8'sd40;
    check_run("k1", 1);
    check_c("k1", 16384, 128, -16256, -127);
    op_a0[0] = 10; op_a1[0] = 20; op_b0[0] = 30; op_b1[0] = 40;
    tick();
    sf_if.in_valid = 1'b0;
    sf_if.in_last  = 1'b0;
    check_run("held", 1);
    check_c("held", 300, 400, 600, 800);

    // Forced last at KMAX with in_last never set
    for (int i = 0; i < 16; i++) begin
      op_a0[i] = i + 1;
      op_a1[i] = -(i + 1);
      op_b0[i] = 2 * i - 15;
      op_b1[i] = 100 - 3 * i;
    end
    load(16, 1'b0);
    check_run("k16", 16);
    check("k16 c11", c11, 680);
    check("k16 c22", c22, -9520);

    // Reset at r=3 of a K=4 run
    for (int i = 0; i < 4; i++) begin
      op_a0[i] = i + 1; op_a1[i] = i + 5; op_b0[i] = i + 9; op_b1[i] = i + 13;
    end
    load(4, 1'b1);
    tick();
    tick();
    tick();
    check("midrst r3 enable", enable, 1);
    reset = 1'b1;
    #1;
    check_quiet("midrst async", 0);
    check("midrst k_len", k_len, 0);
    tick();
    reset = 1'b0;
    check_quiet("midrst released", 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_quiet($sformatf("midrst idle%0d", i), 1);
    end
    set_k2();
    load(2, 1'b1);
    check_run("reload", 2);
    check_c("reload", 19, 22, 43, 50);

`ifdef SYSTOLIC_FEEDER_REPLAY_EN
    replay = 1'b1;
    tick();
    replay = 1'b0;
    check_run("replay", 2);
    check_c("replay", 19, 22, 43, 50);
`else
    replay = 1'b1;
    tick();
    replay = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_quiet($sformatf("noreplay%0d", i), 1);
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
